edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Collects rising-edge events from N asynchronous-to-software input lines (buttons, sensor strobes) and presents them one at a time to a single downstream consumer over a valid/ready handshake. Per-channel saturating pending counters absorb bursts, a round-robin arbiter shares the single output, and a sticky overflow flag marks lost events. It sits between the board input lines and the event-handling logic, replacing per-channel edge detectors that each need their own consumer.

## Interface
- N, default 2: number of input channels, N >= 2.
- CNT_W, default 4: pending-counter width per channel; max pending = 2^CNT_W - 1.
- ID_W, default $clog2(N): width of out_id (derived, not overridden).

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- entrada  in  N  level inputs, already synchronous to clk.
- out_ready  in  1  consumer can accept an event this cycle.
- clr_overflow  in  1  synchronous clear of all overflow bits.
- out_valid  out  1  an event is presented on out_id.
- out_id  out  ID_W  channel index of the presented event.
- overflow  out  N  sticky per-channel "event dropped" flags.
- pending_any  out  1  OR over all pending counters being non-zero (registered state, combinational OR).

## Operation
- Reset: prev_in = 0, all counters = 0, out_valid = 0, out_id = 0, overflow = 0, rr pointer last = N-1 (channel 0 has first priority).
- Edge detect: edge[i] = entrada[i] & ~prev_in[i]; prev_in <= entrada every cycle. Only 0->1 transitions count; held-high input produces one event.
- Counter update per channel, per cycle: +1 on edge[i], -1 on grant[i]; both together -> unchanged. Edge with counter at max and no grant[i] -> counter stays at max, overflow[i] <= 1, event dropped.
- Output register states: EMPTY (out_valid=0) and HOLD (out_valid=1).
  - Load opportunity when EMPTY, or HOLD with out_ready=1 (transfer).
  - At a load opportunity: search channels last+1, last+2, ... (mod N) for first counter > 0 (registered value, before this cycle's edge). If found: grant[i]=1, out_id <= i, out_valid <= 1, last <= i. If none: out_valid <= 0 (HOLD+transfer -> EMPTY).
  - HOLD with out_ready=0: out_valid and out_id held stable, no grant.
- Back-to-back: in HOLD with out_ready held 1 and events pending, one event transfers every cycle.
- overflow: set as above; clr_overflow=1 clears all bits; set and clear on same channel same cycle -> set wins.
- pending_any reflects counters only, not the held output event.

## Timing
- Edge at clock edge E0 (first edge sampling entrada[i]=1 with prev 0): counter[i]=1 after E0; out_valid=1 with out_id=i after E1 if EMPTY. Latency 2 cycles input to valid.
- Transfer occurs at the rising edge where out_valid & out_ready = 1; next event (if pending) is valid in the following cycle without a bubble.
- out_ready is not required to be independent of out_valid; out_valid never depends combinationally on out_ready.
- Reset asserted mid-operation: all state returns to reset values immediately; pending events and held output are discarded; no out_valid pulse on release.

## Test plan
- Single pulse: entrada[0] 0->1 held high 5 cycles, out_ready=1 -> exactly one out_valid cycle, out_id=0, two cycles after the rise; counter back to 0.
- Fairness: both channels rise same cycle, out_ready=1 -> out_id 0 then 1 on consecutive cycles; repeat -> order 0,1 again (last=1).
- Backpressure: out_ready=0, three rises on ch1 -> out_valid=1, out_id=1 stable, counter[1]=2; release out_ready -> three transfers on consecutive cycles, then out_valid=0.
- Overflow (CNT_W=4): out_ready=0, 17 rises on ch0 -> counter[0]=15, first presented plus 15 pending, overflow[0] set on 17th rise; clr_overflow -> overflow=0.
- Simultaneous edge+grant: counter[0]=1, new rise on ch0 in the cycle it is granted -> counter stays 1.
- Mid-operation reset: rst pulsed while out_valid=1 and counters non-zero -> all outputs 0 immediately; no events after release until a new rise.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: per-channel saturating pending counters feeding a
// round-robin arbiter that presents one event at a time over valid/ready.

module edge_event_chan #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lvl,
    input  logic grant,
    input  logic clr_overflow,
    output logic pending,
    output logic overflow
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev;
    logic [CNT_W-1:0] cnt;
    logic             rise;
    logic             drop;

    assign rise    = lvl & ~prev;
    // A rise that cannot be absorbed because the counter is saturated and not draining.
    assign drop    = rise & ~grant & (cnt == CNT_MAX);
    assign pending = |cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= 1'b0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= lvl;
            case ({rise, grant})
                2'b10:   if (!drop) cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;
        end
    end
endmodule

module edge_event_arbiter #(
    parameter int N     = 2,
    parameter int CNT_W = 4,
    parameter int ID_W  = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    entrada,
    input  logic            out_ready,
    input  logic            clr_overflow,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [N-1:0]    overflow,
    output logic            pending_any
);
    typedef enum logic {EMPTY, HOLD} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    pending;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] sel;
    logic            found;
    logic            load;

    for (genvar i = 0; i < N; i++) begin : g_chan
        edge_event_chan #(.CNT_W(CNT_W)) u_chan (
            .clk          (clk),
            .rst          (rst),
            .lvl          (entrada[i]),
            .grant        (grant[i]),
            .clr_overflow (clr_overflow),
            .pending      (pending[i]),
            .overflow     (overflow[i])
        );
    end

    assign pending_any = |pending;
    assign out_valid   = (state_q == HOLD);
    assign load        = (state_q == EMPTY) || out_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        grant   = '0;
        state_d = state_q;
        if (load) begin
            if (found) begin
                grant[sel] = 1'b1;
                state_d    = HOLD;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            out_id  <= '0;
            last    <= ID_W'(N - 1);
        end else begin
            state_q <= state_d;
            if (load && found) begin
                out_id <= sel;
                last   <= sel;
            end
        end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=2, CNT_W=4), one task per scenario.

module tb_edge_event_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] entrada;
    logic       out_ready;
    logic       clr_overflow;
    logic       out_valid;
    logic [0:0] out_id;
    logic [1:0] overflow;
    logic       pending_any;

    int tests = 0;
    int fails = 0;

    edge_event_arbiter #(.N(2), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .entrada      (entrada),
        .out_ready    (out_ready),
        .clr_overflow (clr_overflow),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .overflow     (overflow),
        .pending_any  (pending_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        entrada = 2'b00; out_ready = 1'b0; clr_overflow = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        entrada = 2'b00; out_ready = 1'b0; clr_overflow = 1'b0;
        rst = 1'b1;
        #3;
        tests++;
        if ({out_valid, out_id, overflow, pending_any} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b id=%0d ovf=%b pend=%b, want all 0",
                     out_valid, out_id, overflow, pending_any);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_pulse();
        int nvalid = 0;
        int first  = -1;
        do_reset();
        out_ready = 1'b1;
        entrada   = 2'b01;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) entrada = 2'b00;
            tick();
            if (c == 0) begin
                tests++;
                if (pending_any !== 1'b1) begin
                    fails++;
                    $display("FAIL single_pending: got %b want 1", pending_any);
                end
            end
            if (out_valid) begin
                nvalid++;
                if (first < 0) first = c;
                tests++;
                if (out_id !== 1'b0) begin
                    fails++;
                    $display("FAIL single_id: got %0d want 0", out_id);
                end
            end
        end
        tests++;
        if (nvalid != 1 || first != 1) begin
            fails++;
            $display("FAIL single_count: got %0d valid cycles first at edge %0d, want 1 at edge 1",
                     nvalid, first);
        end
        tests++;
        if (pending_any !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: pending_any got %b want 0", pending_any);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            entrada = 2'b11;
            tick();
            entrada = 2'b00;
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_id !== 1'b0) begin
                fails++;
                $display("FAIL fair_first%0d: got valid=%b id=%0d want 1/0", r, out_valid, out_id);
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_id !== 1'b1) begin
                fails++;
                $display("FAIL fair_second%0d: got valid=%b id=%0d want 1/1", r, out_valid, out_id);
            end
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL fair_idle%0d: got valid=%b want 0", r, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] vhist = '0;
        int bad = 0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            entrada = 2'b10;
            tick();
            entrada = 2'b00;
            tick();
            if (r > 0 && (out_valid !== 1'b1 || out_id !== 1'b1)) bad++;
        end
        tests++;
        if (bad != 0 || out_valid !== 1'b1 || out_id !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: got valid=%b id=%0d unstable=%0d want 1/1/0",
                     out_valid, out_id, bad);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            vhist[c] = out_valid;
            tick();
        end
        tests++;
        if (vhist !== 6'b000111) begin
            fails++;
            $display("FAIL bp_drain: got valid history %b want 000111", vhist);
        end
    endtask

    task automatic test_overflow();
        int xfers = 0;
        do_reset();
        for (int r = 1; r <= 17; r++) begin
            entrada = 2'b01;
            tick();
            entrada = 2'b00;
            tick();
            if (r == 16) begin
                tests++;
                if (overflow !== 2'b00) begin
                    fails++;
                    $display("FAIL ovf_early: got %b want 00 after 16 rises", overflow);
                end
            end
        end
        tests++;
        if (overflow !== 2'b01) begin
            fails++;
            $display("FAIL ovf_set: got %b want 01 after 17 rises", overflow);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) xfers++;
            tick();
        end
        tests++;
        if (xfers != 16 || out_valid !== 1'b0 || pending_any !== 1'b0) begin
            fails++;
            $display("FAIL ovf_drain: got %0d transfers valid=%b pend=%b, want 16/0/0",
                     xfers, out_valid, pending_any);
        end
        tests++;
        if (overflow !== 2'b01) begin
            fails++;
            $display("FAIL ovf_sticky: got %b want 01", overflow);
        end
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tests++;
        if (overflow !== 2'b00) begin
            fails++;
            $display("FAIL ovf_clear: got %b want 00", overflow);
        end
    endtask

    task automatic test_edge_and_grant();
        logic [4:0] vhist = '0;
        do_reset();
        entrada = 2'b01;
        tick();
        entrada = 2'b00;
        tick();
        entrada = 2'b01;
        tick();
        entrada = 2'b00;
        tick();
        // held event plus one pending; new rise lands on the granting edge
        out_ready = 1'b1;
        entrada   = 2'b01;
        for (int c = 0; c < 5; c++) begin
            vhist[c] = out_valid;
            tick();
            entrada = 2'b00;
        end
        tests++;
        if (vhist !== 5'b00111) begin
            fails++;
            $display("FAIL edge_grant: got valid history %b want 00111", vhist);
        end
    endtask

    task automatic test_midop_reset();
        int bad = 0;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            entrada = 2'b11;
            tick();
            entrada = 2'b00;
            tick();
        end
        tests++;
        if (out_valid !== 1'b1 || pending_any !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: got valid=%b pend=%b want 1/1", out_valid, pending_any);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({out_valid, out_id, overflow, pending_any} !== 5'b0) begin
            fails++;
            $display("FAIL mid_async: got valid=%b id=%0d ovf=%b pend=%b want all 0",
                     out_valid, out_id, overflow, pending_any);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (out_valid !== 1'b0 || pending_any !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_quiet: got %0d cycles with activity want 0", bad);
        end
        entrada = 2'b10;
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_id !== 1'b1) begin
            fails++;
            $display("FAIL mid_new: got valid=%b id=%0d want 1/1", out_valid, out_id);
        end
        entrada = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_edge_and_grant();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
